vram_fill: RTL
==============

VRAM_FILL -- requirements
Module: vram_fill

Interface
REQ-001 SHALL provide parameter SCR_W, default 160, meaning screen width in pixels (VRAM row pitch).
REQ-002 SHALL provide parameter SCR_H, default 100, meaning screen height in rows.
REQ-003 SHALL have port cpu_clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to fill a rectangle.
REQ-006 SHALL have port x0  input  8  left column.
REQ-007 SHALL have port y0  input  7  top row.
REQ-008 SHALL have port w  input  8  width in pixels.
REQ-009 SHALL have port h  input  7  height in rows.
REQ-010 SHALL have port color  input  8  RGB332 fill value.
REQ-011 SHALL have port vram_wait  input  1  downstream stall; no write may issue while high.
REQ-012 SHALL have port vram_wr  output  1  VRAM write strobe, registered.
REQ-013 SHALL have port vram_addr  output  14  VRAM byte address, row-major, pitch SCR_W.
REQ-014 SHALL have port vram_data  output  8  VRAM write data.
REQ-015 SHALL have port busy  output  1  high from SETUP through DONE inclusive.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port err  output  1  one-cycle rejection pulse (non-clip build only).

Function
REQ-018 SHALL implement FSM IDLE -> SETUP -> FILL -> DONE -> IDLE.
REQ-019 start SHALL be sampled only in IDLE; start in any other state is ignored.
REQ-020 On start in IDLE, x0/y0/w/h/color SHALL be captured; inputs may change afterwards.
REQ-021 SETUP SHALL compute base address y0*SCR_W+x0 by shift/add, no multiplier, and the effective width and height.
REQ-022 Zero effective area (w==0, h==0, or fully off-screen) SHALL go SETUP -> DONE, with no writes and no err.
REQ-023 In FILL, at each edge with vram_wait low, vram_wr SHALL be set with the current address/color and the position SHALL advance; with vram_wait high, vram_wr SHALL be cleared and the position held.
REQ-024 Position SHALL advance column-first; at the end of a row, the row base SHALL add SCR_W and the column reset.
REQ-025 After the last pixel write, the FSM SHALL enter DONE: done=1 for one cycle, busy=1, then IDLE.
REQ-026 Latency: start at cycle N, with vram_wait low, SHALL give the first write at N+2, the last at N+1+w*h, and done at N+2+w*h.
REQ-027 vram_addr SHALL never exceed SCR_W*SCR_H-1 while vram_wr is high.
REQ-028 vram_wr SHALL be low in IDLE, SETUP and DONE.

Reset
REQ-029 reset SHALL asynchronously force IDLE with vram_wr=0, vram_addr=0, vram_data=0, busy=0, done=0, err=0.
REQ-030 Reset mid-fill SHALL abandon the operation; no further writes; no done pulse.

Configuration
REQ-031 Macro VRAM_FILL_CLIP_EN SHALL select the clipping behaviour.
REQ-032 With VRAM_FILL_CLIP_EN defined, effective w SHALL be min(w, SCR_W-x0) and effective h min(h, SCR_H-y0); if x0>=SCR_W or y0>=SCR_H, the area is zero; err SHALL stay 0.
REQ-033 With VRAM_FILL_CLIP_EN undefined, if x0+w>SCR_W or y0+h>SCR_H (and area nonzero), SETUP SHALL pulse err for one cycle and go to IDLE with no writes and no done; otherwise the fill proceeds unclipped.

Verification
REQ-034 Fill x0=0,y0=0,w=2,h=2,color=0xE0 -> writes to 0,1,160,161 with data 0xE0, done 2+4 cycles after start.
REQ-035 Full screen 160x100, color 0x1C -> 16000 writes, addresses 0..15999 in order, done at N+16002.
REQ-036 x0=158,w=5,y0=99,h=3 -> clip build: writes 15998,15999 then done; non-clip build: err pulse, no writes, no done.
REQ-037 vram_wait high for 3 cycles mid-row of a 4x1 fill -> exactly 4 writes, no address skipped or repeated, done delayed by 3 cycles.
REQ-038 reset asserted after the 2nd write of a 4x4 fill -> outputs zero immediately, no done; next start fills normally.
REQ-039 start pulsed while busy with different parameters -> ignored; only the first rectangle is written.

Source files
------------

// File: rtl/vram_fill.sv
// vram_fill: rectangle fill engine for a row-major 8-bit VRAM.
// A start request in IDLE captures the rectangle. SETUP derives the base address
// with shifts and adds, and also derives the effective size. FILL then emits one
// write per unstalled cycle, column first. DONE pulses completion.
// Optional feature: define VRAM_FILL_CLIP_EN to clip rectangles to the screen.
// Without it, rectangles that overhang the screen are rejected with an err pulse.
module vram_fill #(
  parameter int SCR_W = 160,
  parameter int SCR_H = 100
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [6:0]  y0,
  input  logic [7:0]  w,
  input  logic [6:0]  h,
  input  logic [7:0]  color,
  input  logic        vram_wait,
  output logic        vram_wr,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [13:0] SCR_W14 = 14'(SCR_W);
  localparam logic [8:0]  SCR_W9  = 9'(SCR_W);
  localparam logic [7:0]  SCR_H8  = 8'(SCR_H);

  logic [1:0]  state_q, state_d;
  logic [7:0]  x0_q, x0_d, w_q, w_d, color_q, color_d;
  logic [6:0]  y0_q, y0_d, h_q, h_d;
  logic [13:0] row_base_q, row_base_d;
  logic [7:0]  col_q, col_d, ew_q, ew_d;
  logic [6:0]  row_q, row_d, eh_q, eh_d;
  logic        fin_q, fin_d;
  logic        wr_q, wr_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;

  // Base address y0*SCR_W + x0 as a sum of shifted copies of y0, one per set bit of SCR_W.
  logic [13:0] base_acc [0:14];
  assign base_acc[0] = {6'd0, x0_q};
  generate
    for (genvar gi = 0; gi < 14; gi++) begin : g_base
      if (SCR_W14[gi]) begin : g_add
        assign base_acc[gi+1] = base_acc[gi] + (14'(y0_q) << gi);
      end else begin : g_pass
        assign base_acc[gi+1] = base_acc[gi];
      end
    end
  endgenerate

  logic [7:0] ew_calc;
  logic [6:0] eh_calc;
  logic       zero_calc, err_calc;

`ifdef VRAM_FILL_CLIP_EN
  logic [8:0] room_x;
  logic [7:0] room_y;
  logic       off_screen;

  // Clip the rectangle to the visible area; fully off-screen means nothing to draw.
  always_comb begin
    room_x     = SCR_W9 - {1'b0, x0_q};
    room_y     = SCR_H8 - {1'b0, y0_q};
    off_screen = ({1'b0, x0_q} >= SCR_W9) || ({1'b0, y0_q} >= SCR_H8);
    ew_calc    = ({1'b0, w_q} > room_x) ? room_x[7:0] : w_q;
    eh_calc    = ({1'b0, h_q} > room_y) ? room_y[6:0] : h_q;
    zero_calc  = off_screen || (w_q == 8'd0) || (h_q == 7'd0);
    err_calc   = 1'b0;
  end
`else
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  // Draw unclipped; an empty rectangle is a no-op, any overhang is rejected.
  always_comb begin
    sum_x     = {1'b0, x0_q} + {1'b0, w_q};
    sum_y     = {1'b0, y0_q} + {1'b0, h_q};
    ew_calc   = w_q;
    eh_calc   = h_q;
    zero_calc = (w_q == 8'd0) || (h_q == 7'd0);
    err_calc  = !zero_calc && ((sum_x > SCR_W9) || (sum_y > SCR_H8));
  end
`endif

  logic last_col, last_row;
  assign last_col = (col_q == ew_q - 8'd1);
  assign last_row = (row_q == eh_q - 7'd1);

  // Next-state logic for the control FSM, position counters and output registers.
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    ew_d       = ew_q;
    eh_d       = eh_q;
    fin_d      = fin_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = w;
          h_d     = h;
          color_d = color;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        row_base_d = base_acc[14];
        ew_d       = ew_calc;
        eh_d       = eh_calc;
        col_d      = 8'd0;
        row_d      = 7'd0;
        fin_d      = 1'b0;
        if (zero_calc) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (err_calc) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        // The cycle after the last write drops the strobe before entering DONE.
        if (fin_q) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (!vram_wait) begin
          wr_d   = 1'b1;
          addr_d = row_base_q + {6'd0, col_q};
          data_d = color_q;
          if (last_col) begin
            col_d      = 8'd0;
            row_d      = row_q + 7'd1;
            row_base_d = row_base_q + SCR_W14;
            fin_d      = last_row;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any fill in progress.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x0_q       <= 8'd0;
      y0_q       <= 7'd0;
      w_q        <= 8'd0;
      h_q        <= 7'd0;
      color_q    <= 8'd0;
      row_base_q <= 14'd0;
      col_q      <= 8'd0;
      row_q      <= 7'd0;
      ew_q       <= 8'd0;
      eh_q       <= 7'd0;
      fin_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 14'd0;
      data_q     <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      ew_q       <= ew_d;
      eh_q       <= eh_d;
      fin_q      <= fin_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign vram_wr   = wr_q;
  assign vram_addr = addr_q;
  assign vram_data = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
